pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter stage for the single-cycle MIPS core; successor to the plain 32-bit PC register.
- Holds the fetch address and computes the next PC internally: sequential, branch, jump, jump-register.
- Adds a stall hold, a configurable reset vector and a small return-address stack (RAS) for jal/jr $ra.
- Sits between control/ALU-zero logic and instruction memory.

Parameters:
- WIDTH, 32, PC width in bits; must be at least 30.
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits, word-aligned).
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- startin_n  in  1  synchronous active-low reset.
- stall  in  1  hold the PC and RAS this cycle.
- sel  in  2  next-PC mode: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- branch_taken  in  1  branch condition; qualifies sel=01.
- branch_off  in  WIDTH  sign-extended word offset.
- jump_target  in  26  instruction index field.
- jreg_addr  in  WIDTH  register-file rs value.
- ras_push  in  1  jal: push the return address.
- ras_pop  in  1  jr $ra: take the target from the RAS.
- pc_out  out  WIDTH  current fetch address (registered).
- pc_plus4  out  WIDTH  pc_out+4 (combinational).
- ras_hit  out  1  pop serviced from the RAS this cycle (combinational).
- ras_empty  out  1  RAS count is 0 (registered state).

Behaviour:
- Reset:
  - Synchronous active-low. On a clk edge with startin_n=0: pc_out=RESET_VEC, RAS count=0, top pointer=0.
  - Reset overrides stall, push and pop. A mid-operation reset discards all RAS contents.
- Arithmetic: all additions are modulo 2^WIDTH; wrap-around is silent. pc_plus4 = pc_out+4.
- Next-PC selection:
  - sel=00, or sel=01 with branch_taken=0: next = pc_plus4.
  - sel=01 with branch_taken=1: next = pc_plus4 + (branch_off<<2).
  - sel=10: next = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
  - sel=11, ras_pop=0: next = jreg_addr.
  - sel=11, ras_pop=1, RAS non-empty: next = RAS top; ras_hit=1.
  - sel=11, ras_pop=1, RAS empty: next = jreg_addr; ras_hit=0.
  - ras_pop with sel other than 11 is ignored (no pop, ras_hit=0).
- Update:
  - With stall=0, each edge loads next into pc_out (1-cycle latency).
  - With stall=1, pc_out and the RAS are unchanged and push/pop are ignored. ras_hit is still computed combinationally but has no effect.
- RAS is a circular buffer:
  - Push writes pc_plus4 to top+1 and advances top. Count saturates at RAS_DEPTH; a push when full overwrites the oldest entry.
  - A pop that hits decrements top and count.
  - Push and a hitting pop together: the top entry is replaced by pc_plus4; top and count are unchanged; next = old top value.
  - Push and pop when empty: push only; next = jreg_addr.
- Misaligned jreg_addr is passed through unchanged; detection belongs to a later block.

Optional Feature:
- Macro PC_SEQ_TRACE_EN.
- Defined: on every non-stalled, non-reset edge, simulation prints "pc <old> -> <new> sel=<sel> ras=<count>". On reset it prints "pc reset".
- Undefined: no display statements are compiled; RTL behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - sel encodings: PC_SEL_SEQ, PC_SEL_BR, PC_SEL_J, PC_SEL_JR.
  - the constant INSTR_BYTES=4.
  - the default RESET_VEC.
- One sub-module, pc_ras (circular stack with push/pop/replace and count), parametrised by WIDTH and RAS_DEPTH. Next-PC mux and PC register stay in pc_sequencer.

Test Plan:
- Reset then sequential: startin_n=0 for 1 edge, then sel=00 for 3 edges -> pc_out 0, 4, 8, 12.
- Branch and stall:
  - At pc=0x10, sel=01, taken=1, off=-2 -> pc=0x0C.
  - taken=0 -> pc=0x14.
  - stall=1 for 2 edges -> pc holds.
- Jump:
  - At pc=0x4000_0000, sel=10, target=0x000_0040 -> pc=0x4000_0100.
  - At pc=0xFFFF_FFFC, sel=00 -> pc wraps to 0.
- RAS push/pop:
  - jal at 0x100 (push) -> top=0x104.
  - Later sel=11, pop=1, jreg_addr=0xDEAD_0000 -> pc=0x104, ras_hit=1, ras_empty=1 after.
- RAS overflow/underflow (RAS_DEPTH=4):
  - 5 pushes from 0x0, 0x10, 0x20, 0x30, 0x40 -> pops return 0x44, 0x34, 0x24, 0x14.
  - 5th pop -> jreg_addr, ras_hit=0.
- Simultaneous and reset:
  - Push+pop with top=0x204 at pc=0x300 -> pc=0x204, top becomes 0x304, count unchanged.
  - startin_n=0 during stall=1 -> pc=RESET_VEC, ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes,
// instruction size and the default reset vector.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ = 2'b00,
        PC_SEL_BR  = 2'b01,
        PC_SEL_J   = 2'b10,
        PC_SEL_JR  = 2'b11
    } pc_sel_e;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, hitting pop, push+pop replace of the
// top entry, saturating count. Pushing when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           startin_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               top_data,
    output logic [$clog2(RAS_DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic             pop_ok;

    // A pop against an empty stack never moves the pointer.
    assign pop_ok   = pop && (count != '0);
    assign top_data = mem[top];

    always_ff @(posedge clk) begin
        if (!startin_n) begin
            top   <= '0;
            count <= '0;
        end else if (push && !pop_ok) begin
            top <= top + PW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop_ok && !push) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Storage has no reset; entries above count are never read as valid.
    always_ff @(posedge clk) begin
        if (startin_n) begin
            if (push && pop_ok) begin
                mem[top] <= wdata;
            end else if (push) begin
                mem[top + PW'(1)] <= wdata;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: next-PC mux, stall hold, reset vector and RAS.
// Define PC_SEQ_TRACE_EN to print a per-update trace in simulation.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             startin_n,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_off,
    input  logic [25:0]      jump_target,
    input  logic [WIDTH-1:0] jreg_addr,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_hit,
    output logic             ras_empty
);

    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_push_en;
    logic             ras_pop_en;

    assign pc_plus4    = pc_out + WIDTH'(INSTR_BYTES);
    assign ras_empty   = (ras_count == '0);
    assign ras_hit     = (pc_sel_e'(sel) == PC_SEL_JR) && ras_pop && !ras_empty;
    assign ras_push_en = ras_push && !stall;
    assign ras_pop_en  = ras_hit && !stall;

    // Next-PC select; all sums wrap modulo 2^WIDTH.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel_e'(sel))
            PC_SEL_SEQ: next_pc = pc_plus4;
            PC_SEL_BR:  if (branch_taken) next_pc = pc_plus4 + (branch_off << 2);
            PC_SEL_J:   next_pc = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
            PC_SEL_JR:  next_pc = ras_hit ? ras_top : jreg_addr;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!startin_n) begin
            pc_out <= RESET_VEC;
        end else if (!stall) begin
            pc_out <= next_pc;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .startin_n (startin_n),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .wdata     (pc_plus4),
        .top_data  (ras_top),
        .count     (ras_count)
    );

`ifdef PC_SEQ_TRACE_EN
    always_ff @(posedge clk) begin
        if (!startin_n) begin
            $display("pc reset");
        end else if (!stall) begin
            $display("pc %h -> %h sel=%0d ras=%0d", pc_out, next_pc, sel, ras_count);
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, then random
// stimulus compared against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        startin_n;
    logic        stall;
    logic [1:0]  sel;
    logic        branch_taken;
    logic [31:0] branch_off;
    logic [25:0] jump_target;
    logic [31:0] jreg_addr;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        ras_hit;
    logic        ras_empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [1:0]  sel;
        logic        taken;
        logic [31:0] off;
        logic [25:0] tgt;
        logic [31:0] jreg;
        logic        push;
        logic        pop;
        logic        exp_hit;
        logic [31:0] exp_pc;
        logic        exp_empty;
    } vec_t;

    vec_t tbl[$];

    // Reference model: PC value plus the RAS as a bounded queue (back = top).
    logic [31:0] mpc;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .startin_n    (startin_n),
        .stall        (stall),
        .sel          (sel),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_target  (jump_target),
        .jreg_addr    (jreg_addr),
        .ras_push     (ras_push),
        .ras_pop      (ras_pop),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .ras_hit      (ras_hit),
        .ras_empty    (ras_empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic stl, input logic [1:0] s,
                       input logic tk, input logic [31:0] off, input logic [25:0] tgt,
                       input logic [31:0] jr, input logic psh, input logic pp,
                       input logic hit, input logic [31:0] pc, input logic emp);
        vec_t v;
        v.rst_n = rst_n; v.stall = stl; v.sel = s; v.taken = tk; v.off = off;
        v.tgt = tgt; v.jreg = jr; v.push = psh; v.pop = pp;
        v.exp_hit = hit; v.exp_pc = pc; v.exp_empty = emp;
        tbl.push_back(v);
    endtask

    // One clock: drive, check combinational outputs, clock, check state.
    task automatic run(input vec_t v, input bit use_model, input string tag);
        logic [31:0] p4;
        logic [31:0] nxt;
        bit          hit;
        @(negedge clk);
        startin_n    = v.rst_n;
        stall        = v.stall;
        sel          = v.sel;
        branch_taken = v.taken;
        branch_off   = v.off;
        jump_target  = v.tgt;
        jreg_addr    = v.jreg;
        ras_push     = v.push;
        ras_pop      = v.pop;

        p4  = mpc + 32'd4;
        hit = (v.sel == 2'd3) && v.pop && (mq.size() > 0);
        case (v.sel)
            2'd0:    nxt = p4;
            2'd1:    nxt = v.taken ? p4 + v.off * 32'd4 : p4;
            2'd2:    nxt = (p4 & 32'hF000_0000) + {6'd0, v.tgt} * 32'd4;
            default: nxt = hit ? mq[$] : v.jreg;
        endcase

        #1;
        if (use_model) begin
            check({tag, " ras_hit"}, {31'd0, ras_hit}, {31'd0, hit});
            check({tag, " pc_plus4"}, pc_plus4, p4);
        end else begin
            check({tag, " ras_hit"}, {31'd0, ras_hit}, {31'd0, v.exp_hit});
        end

        @(posedge clk);
        if (!v.rst_n) begin
            mpc = 32'd0;
            mq.delete();
        end else if (!v.stall) begin
            if (v.push && hit) begin
                mq[mq.size()-1] = p4;
            end else begin
                if (hit) void'(mq.pop_back());
                if (v.push) begin
                    mq.push_back(p4);
                    if (mq.size() > 4) void'(mq.pop_front());
                end
            end
            mpc = nxt;
        end

        #1;
        if (use_model) begin
            check({tag, " pc_out"}, pc_out, mpc);
            check({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, mq.size() == 0});
        end else begin
            check({tag, " pc_out"}, pc_out, v.exp_pc);
            check({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, v.exp_empty});
        end
    endtask

    initial begin
        vec_t rv;
        startin_n = 1'b0; stall = 1'b0; sel = 2'd0; branch_taken = 1'b0;
        branch_off = '0; jump_target = '0; jreg_addr = '0; ras_push = 1'b0; ras_pop = 1'b0;

        //   rst stl sel tk  off           tgt         jreg          psh pop hit pc            emp
        add(0, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'h0,        1);
        add(1, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'h4,        1);
        add(1, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'h8,        1);
        add(1, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'hC,        1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h10,       0, 0, 0, 32'h10,       1);
        add(1, 0, 2'd1, 1, 32'hFFFFFFFE, 26'h0,      32'h0,        0, 0, 0, 32'hC,        1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h10,       0, 0, 0, 32'h10,       1);
        add(1, 0, 2'd1, 0, 32'hFFFFFFFE, 26'h0,      32'h0,        0, 0, 0, 32'h14,       1);
        add(1, 1, 2'd2, 0, 32'h0,        26'h3FFFFFF,32'h0,        0, 0, 0, 32'h14,       1);
        add(1, 1, 2'd3, 0, 32'h0,        26'h0,      32'h0,        1, 1, 0, 32'h14,       1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h40000000, 0, 0, 0, 32'h40000000, 1);
        add(1, 0, 2'd2, 0, 32'h0,        26'h40,     32'h0,        0, 0, 0, 32'h40000100, 1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 1);
        add(1, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'h0,        1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h100,      0, 0, 0, 32'h100,      1);
        add(1, 0, 2'd2, 0, 32'h0,        26'h80,     32'h0,        1, 0, 0, 32'h200,      0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'hDEAD0000, 0, 1, 1, 32'h104,      1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'hDEAD0000, 0, 1, 0, 32'hDEAD0000, 1);
        add(1, 0, 2'd1, 0, 32'h0,        26'h0,      32'h0,        0, 1, 0, 32'hDEAD0004, 1);
        // Overflow: five pushes into a four-entry stack, then five pops.
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h0,        0, 0, 0, 32'h0,        1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h10,       1, 0, 0, 32'h10,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h20,       1, 0, 0, 32'h20,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h30,       1, 0, 0, 32'h30,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h40,       1, 0, 0, 32'h40,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h1000,     1, 0, 0, 32'h1000,     0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h9000,     0, 1, 1, 32'h44,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h9000,     0, 1, 1, 32'h34,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h9000,     0, 1, 1, 32'h24,       0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h9000,     0, 1, 1, 32'h14,       1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h9000,     0, 1, 0, 32'h9000,     1);
        // Simultaneous push+pop replaces the top entry.
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h200,      0, 0, 0, 32'h200,      1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h300,      1, 0, 0, 32'h300,      0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'hBEEF,     1, 1, 1, 32'h204,      0);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h0,        0, 1, 1, 32'h304,      1);
        add(1, 0, 2'd0, 0, 32'h0,        26'h0,      32'h0,        1, 0, 0, 32'h308,      0);
        add(1, 1, 2'd3, 0, 32'h0,        26'h0,      32'h1,        0, 1, 1, 32'h308,      0);
        // Reset during stall with push/pop asserted discards the stack.
        add(0, 1, 2'd3, 0, 32'h0,        26'h0,      32'h5,        1, 1, 1, 32'h0,        1);
        add(1, 0, 2'd3, 0, 32'h0,        26'h0,      32'h77C,      0, 1, 0, 32'h77C,      1);

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 400; i++) begin
            rv.rst_n     = ($urandom_range(0, 59) != 0);
            rv.stall     = ($urandom_range(0, 6) == 0);
            rv.sel       = 2'($urandom_range(0, 3));
            rv.taken     = 1'($urandom_range(0, 1));
            rv.off       = 32'($signed(12'($urandom)));
            rv.tgt       = 26'($urandom);
            rv.jreg      = $urandom;
            rv.push      = ($urandom_range(0, 2) == 0);
            rv.pop       = ($urandom_range(0, 4) < 2);
            rv.exp_hit   = 1'b0;
            rv.exp_pc    = 32'd0;
            rv.exp_empty = 1'b0;
            run(rv, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
